// File: rtl/score_counter.sv
// score_counter: DIGITS-digit BCD pipe counter with edge-detected in, sync clear, async active-low reset, session high score, sticky new_high, wrap/saturate, carry pulse out, max flag and blanked 7-seg HEX
module score_counter #(
  parameter int DIGITS = 3,
  parameter int SATURATE = 0,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  out,
  output logic                  max,
  output logic                  new_high
);
  logic in_q, inc, wrap;
  logic [4*DIGITS-1:0] incd, nxt;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1000000;
    endcase
  endfunction
  always_comb begin : bcd_inc
    logic c;
    logic [3:0] d;
    c = 1'b1;
    incd = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d = score[4*k+:4];
      incd[4*k+:4] = d > 4'd9 ? 4'd0 : !c ? d : d == 4'd9 ? 4'd0 : d + 4'd1;
      c = c & (d == 4'd9);
    end
    max = c;
  end
  assign inc  = in & ~in_q;
  assign wrap = ~clear & inc & max & (SATURATE == 0);
  assign nxt  = clear ? '0 : !inc ? score : !max ? incd : SATURATE != 0 ? score : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q     <= 1'b0;
      score    <= '0;
      high     <= '0;
      out      <= 1'b0;
      new_high <= 1'b0;
    end else begin
      in_q  <= in;
      score <= nxt;
      out   <= wrap;
      if (clear) new_high <= 1'b0;
      if (nxt > high) begin
        high     <= nxt;
        new_high <= 1'b1;
      end
    end
  end
  always_comb begin : hex_drive
    logic nz;
    logic [3:0] d;
    nz = 1'b0;
    HEX = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      d = score[4*k+:4];
      nz = nz | (d != 4'd0);
      HEX[7*k+:7] = (BLANK_LEADING != 0 && k != 0 && !nz) ? 7'h7f : seg(d);
    end
  end
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: random and directed stimulus on wrap and saturate instances against an integer reference model
module tb_score_counter;
  logic clk = 1'b0, rst = 1'b0, din = 1'b0, clr = 1'b0;
  logic [11:0] score_o[2], high_o[2];
  logic [20:0] hex_o[2];
  logic out_o[2], max_o[2], nh_o[2];
  int m_score[2], m_high[2];
  bit m_out[2], m_nh[2], prev_in;
  int compared = 0, mismatched = 0;
  const logic [6:0] segs[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  always #5 clk = ~clk;
  score_counter #(.DIGITS(3), .SATURATE(0), .BLANK_LEADING(1)) dut_w (
    .clk(clk), .reset(rst), .in(din), .clear(clr), .score(score_o[0]), .high(high_o[0]),
    .HEX(hex_o[0]), .out(out_o[0]), .max(max_o[0]), .new_high(nh_o[0]));
  score_counter #(.DIGITS(3), .SATURATE(1), .BLANK_LEADING(1)) dut_s (
    .clk(clk), .reset(rst), .in(din), .clear(clr), .score(score_o[1]), .high(high_o[1]),
    .HEX(hex_o[1]), .out(out_o[1]), .max(max_o[1]), .new_high(nh_o[1]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [11:0] to_bcd(input int v);
    return 12'((v / 100) % 10 << 8 | (v / 10) % 10 << 4 | v % 10);
  endfunction
  function automatic logic [20:0] exp_hex(input int v);
    logic [20:0] h;
    int p = 1;
    for (int k = 0; k < 3; k++) begin
      h[7*k+:7] = (k > 0 && v < p) ? 7'h7f : segs[(v / p) % 10];
      p *= 10;
    end
    return h;
  endfunction
  task automatic model_reset();
    prev_in = 0;
    for (int j = 0; j < 2; j++) begin
      m_score[j] = 0; m_high[j] = 0; m_out[j] = 0; m_nh[j] = 0;
    end
  endtask
  task automatic model_step();
    bit inc = din && !prev_in;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int j = 0; j < 2; j++) begin
      m_out[j] = 0;
      if (clr) begin
        m_score[j] = 0;
        m_nh[j] = 0;
      end else if (inc) begin
        if (m_score[j] < 999) m_score[j]++;
        else if (j == 0) begin
          m_score[j] = 0;
          m_out[j] = 1;
        end
      end
      if (m_score[j] > m_high[j]) begin
        m_high[j] = m_score[j];
        m_nh[j] = 1;
      end
    end
    prev_in = din;
  endtask
  task automatic check_all();
    for (int j = 0; j < 2; j++) begin
      check(j ? "sat score" : "wrap score", 32'(score_o[j]), 32'(to_bcd(m_score[j])));
      check(j ? "sat high" : "wrap high", 32'(high_o[j]), 32'(to_bcd(m_high[j])));
      check(j ? "sat hex" : "wrap hex", 32'(hex_o[j]), 32'(exp_hex(m_score[j])));
      check(j ? "sat out" : "wrap out", 32'(out_o[j]), 32'(m_out[j]));
      check(j ? "sat max" : "wrap max", 32'(max_o[j]), 32'(m_score[j] == 999));
      check(j ? "sat new_high" : "wrap new_high", 32'(nh_o[j]), 32'(m_nh[j]));
    end
  endtask
  task automatic cycle(input logic i, input logic c);
    din = i;
    clr = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask
  task automatic pulses(input int n);
    for (int p = 0; p < n; p++) begin
      cycle(1, 0);
      cycle(0, 0);
    end
  endtask
  initial begin
    model_reset();
    #1 check_all();
    cycle(0, 0);
    cycle(0, 0);
    rst = 1;
    cycle(0, 0);
    check("idle hex", 32'(hex_o[0]), 32'h1fffc0);
    for (int r = 0; r < 12; r++) begin
      repeat (5) cycle(1, 0);
      cycle(0, 0);
    end
    check("edge12 score", 32'(score_o[0]), 32'h012);
    check("edge12 hex", 32'(hex_o[0]), {11'h0, 7'h7f, 7'b1111001, 7'b0100100});
    cycle(0, 1);
    pulses(25);
    cycle(0, 1);
    pulses(10);
    check("hi25", 32'(high_o[0]), 32'h025);
    check("nh after clear", 32'(nh_o[0]), 32'h0);
    pulses(15);
    check("nh at 25", 32'(nh_o[0]), 32'h0);
    cycle(1, 0);
    check("hi26", 32'(high_o[0]), 32'h026);
    check("nh at 26", 32'(nh_o[0]), 32'h1);
    cycle(0, 1);
    pulses(999);
    check("max at 999 wrap", 32'(max_o[0]), 32'h1);
    cycle(1, 0);
    check("wrap out", 32'(out_o[0]), 32'h1);
    check("wrap score", 32'(score_o[0]), 32'h000);
    check("wrap high kept", 32'(high_o[0]), 32'h999);
    check("sat holds", 32'(score_o[1]), 32'h999);
    cycle(0, 0);
    check("wrap out one cycle", 32'(out_o[0]), 32'h0);
    pulses(3);
    check("sat after 3", 32'(score_o[1]), 32'h999);
    check("sat max", 32'(max_o[1]), 32'h1);
    cycle(1, 1);
    check("clear beats inc", 32'(score_o[1]), 32'h000);
    cycle(1, 0);
    check("held level not recounted", 32'(score_o[1]), 32'h000);
    cycle(0, 0);
    pulses(47);
    check("at 47", 32'(score_o[0]), 32'h047);
    rst = 0;
    #2;
    model_reset();
    check_all();
    cycle(0, 0);
    rst = 1;
    cycle(1, 0);
    check("in high at release", 32'(score_o[0]), 32'h001);
    for (int r = 0; r < 3000; r++) begin
      rst = $urandom_range(0, 299) != 0;
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
